// File: rtl/dft_pkg.sv
// Shared constants for the DFT capture datapath: FSM state encoding and
// default geometry used by both the capture path and the DFT controller.
package dft_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DFT_WIDTH  = 32;
  localparam int DFT_DEPTH  = 8;
  localparam int DFT_NUM_CH = 4;
  localparam int DFT_LEN_W  = 16;

  // Width of a chain-select field; a single chain still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dft_word_fifo.sv
// Show-ahead word FIFO: the head word and its valid flag are registered, so
// the consumer sees data the cycle after it is pushed into an empty queue.
module dft_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_val,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             val_q, val_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && val_q;
  assign out_data = data_q;
  assign out_val  = val_q;
  assign count    = count_q;

  // Storage array; written on every accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  // Next pointers, occupancy and head word; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (pop_ok && count_q > (AW+1)'(1)) begin
      data_d = mem[rd_ptr_q + AW'(1)];
    end else if (push_ok && (empty || (pop_ok && count_q == (AW+1)'(1)))) begin
      data_d = push_data;
    end
    val_d = (count_d != '0);
  end

  // Pointer/occupancy/head registers; clear flushes the queue like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      val_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      val_q    <= val_d;
    end
  end

endmodule

// File: rtl/dft_capture_path.sv
// DFT capture path: shifts a selected scan chain, packs bits LSB-first into
// words, and queues them for the host; a full queue stalls the chain.
module dft_capture_path
  import dft_pkg::*;
#(
  parameter int WIDTH  = DFT_WIDTH,
  parameter int DEPTH  = DFT_DEPTH,
  parameter int NUM_CH = DFT_NUM_CH,
  parameter int LEN_W  = DFT_LEN_W,
  localparam int CH_W  = sel_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      dft_sin,
  output logic                   sc_sen,
  input  logic                   start,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [LEN_W-1:0]       shift_len,
  input  logic                   abort,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic             fifo_full, fifo_empty;
  logic             sel_bit, push;
  logic [WIDTH-1:0] push_data;

  assign sel_bit   = dft_sin[ch_q];
  assign sc_sen    = (state_q == ST_SHIFT) && !fifo_full;
  assign push      = sc_sen && ((bit_idx_q == IDX_W'(WIDTH-1)) || (remaining_q == LEN_W'(1)));
  // Bits above the newest one are still zero, which pads a short final word.
  assign push_data = shreg_q | ({{(WIDTH-1){1'b0}}, sel_bit} << bit_idx_q);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && fifo_empty && !abort;

  dft_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort),
    .push      (push),
    .push_data (push_data),
    .pop       (out_rdy),
    .out_data  (out_data),
    .out_val   (out_val),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (word_cnt)
  );

  // Capture FSM and bit/length counters; abort overrides everything but reset.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    remaining_d = remaining_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_d        = (int'(ch_sel) < NUM_CH) ? ch_sel : '0;
          remaining_d = shift_len;
          bit_idx_d   = '0;
          shreg_d     = '0;
          state_d     = (shift_len == '0) ? ST_DRAIN : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sc_sen) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (push) begin
            bit_idx_d = '0;
            shreg_d   = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shreg_d   = push_data;
          end
          if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      ch_d        = '0;
      remaining_d = '0;
      bit_idx_d   = '0;
      shreg_d     = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      remaining_q <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      remaining_q <= remaining_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
    end
  end

endmodule

// File: tb/tb_dft_capture_path.sv
// Directed bench for dft_capture_path: drives a bit stream on the selected
// chain (inverted on the others) and checks the packed words and handshakes.
module tb_dft_capture_path;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] dft_sin;
  logic              sc_sen;
  logic              start;
  logic [1:0]        ch_sel;
  logic [LEN_W-1:0]  shift_len;
  logic              abort;
  logic [WIDTH-1:0]  out_data;
  logic              out_val;
  logic              out_rdy;
  logic              busy;
  logic              done;
  logic [3:0]        word_cnt;

  dft_capture_path #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .NUM_CH (NUM_CH), .LEN_W (LEN_W)
  ) dut (
    .clk (clk), .reset (reset), .dft_sin (dft_sin), .sc_sen (sc_sen),
    .start (start), .ch_sel (ch_sel), .shift_len (shift_len), .abort (abort),
    .out_data (out_data), .out_val (out_val), .out_rdy (out_rdy),
    .busy (busy), .done (done), .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] src_words [0:15];
  logic        stream [0:511];
  int          n_bits, bit_ptr, cur_ch;
  int          sen_cycles, done_cnt, done_cyc, last_pop, cyc, stall_cnt, max_cnt;
  bit          bp_mode;
  logic [31:0] got [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive scan data, apply back-pressure policy, record activity.
  task automatic tick();
    logic b;
    b = (bit_ptr < n_bits) ? stream[bit_ptr] : 1'b0;
    for (int c = 0; c < NUM_CH; c++) dft_sin[c] = (c == cur_ch) ? b : ~b;
    if (bp_mode && word_cnt == 4'(DEPTH) && busy) begin
      check("stall_sen_low_when_full", {63'd0, sc_sen}, 64'd0);
      stall_cnt++;
      if (stall_cnt == 3) begin
        out_rdy = 1'b1;
        bp_mode = 1'b0;
      end
    end
    if (int'(word_cnt) > max_cnt) max_cnt = int'(word_cnt);
    if (sc_sen) begin
      sen_cycles++;
      bit_ptr++;
    end
    if (out_val && out_rdy) begin
      got.push_back(out_data);
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Build the selected-chain bit stream LSB-first from src_words.
  task automatic prep(input int ch, input int nbits);
    cur_ch = ch;
    n_bits = nbits;
    for (int i = 0; i < 512; i++) stream[i] = src_words[(i / 32) % 16][i % 32];
    bit_ptr = 0; sen_cycles = 0; done_cnt = 0; done_cyc = -1; last_pop = -1;
    stall_cnt = 0; max_cnt = 0;
    got.delete();
  endtask

  task automatic start_capture(input logic [1:0] ch, input logic [LEN_W-1:0] len);
    ch_sel = ch; shift_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ch_sel = '0; shift_len = '0;
    out_rdy = 1'b1; dft_sin = '0; bp_mode = 1'b0; cyc = 0;
    for (int i = 0; i < 16; i++) src_words[i] = '0;
    prep(0, 0);
    repeat (3) tick();
    check("rst_sc_sen",   {63'd0, sc_sen},   64'd0);
    check("rst_out_val",  {63'd0, out_val},  64'd0);
    check("rst_busy",     {63'd0, busy},     64'd0);
    check("rst_done",     {63'd0, done},     64'd0);
    check("rst_word_cnt", 64'(word_cnt),     64'd0);
    check("rst_out_data", 64'(out_data),     64'd0);
    reset = 1'b0;
    tick();

    // Basic capture on chain 1, two full words.
    src_words[0] = 32'hA5A5A5A5; src_words[1] = 32'h12345678;
    prep(1, 64);
    start_capture(2'd1, 16'd64);
    check("basic_busy_after_start", {63'd0, busy}, 64'd1);
    run_to_done("basic", 300);
    check("basic_nwords", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("basic_word0", 64'(got[0]), 64'hA5A5A5A5);
      check("basic_word1", 64'(got[1]), 64'h12345678);
    end
    check("basic_sen_cycles", 64'(sen_cycles), 64'd64);
    check("basic_done_after_pop", 64'(done_cyc), 64'(last_pop + 1));
    check("basic_idle_after_done", {63'd0, busy}, 64'd0);
    repeat (2) tick();
    check("basic_single_done", 64'(done_cnt), 64'd1);

    // Partial final word, all-ones input on chain 2.
    src_words[0] = 32'hFFFFFFFF; src_words[1] = 32'hFFFFFFFF;
    prep(2, 64);
    start_capture(2'd2, 16'd40);
    run_to_done("partial", 300);
    check("partial_nwords", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("partial_word0", 64'(got[0]), 64'hFFFFFFFF);
      check("partial_word1", 64'(got[1]), 64'h000000FF);
    end
    check("partial_sen_cycles", 64'(sen_cycles), 64'd40);

    // Back-pressure: ten words with the consumer stalled until the queue fills.
    src_words[0] = 32'h01234567; src_words[1] = 32'h89ABCDEF;
    src_words[2] = 32'hDEADBEEF; src_words[3] = 32'hCAFEF00D;
    src_words[4] = 32'h0F0F0F0F; src_words[5] = 32'hF0E1D2C3;
    src_words[6] = 32'h13579BDF; src_words[7] = 32'h2468ACE0;
    src_words[8] = 32'h80000001; src_words[9] = 32'h7FFFFFFE;
    prep(3, 320);
    out_rdy = 1'b0;
    bp_mode = 1'b1;
    start_capture(2'd3, 16'd320);
    run_to_done("bp", 2000);
    check("bp_max_word_cnt", 64'(max_cnt), 64'(DEPTH));
    check("bp_stall_cycles", 64'(stall_cnt), 64'd3);
    check("bp_nwords", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      check($sformatf("bp_word%0d", i), 64'(got[i]), 64'(src_words[i]));
    check("bp_sen_cycles", 64'(sen_cycles), 64'd320);
    out_rdy = 1'b1;
    bp_mode = 1'b0;

    // Zero-length capture.
    prep(0, 0);
    start_capture(2'd0, 16'd0);
    check("zero_busy_after_start", {63'd0, busy}, 64'd1);
    run_to_done("zero", 20);
    check("zero_sen_cycles", 64'(sen_cycles), 64'd0);
    check("zero_nwords", 64'(got.size()), 64'd0);

    // Abort after three queued words, then a clean follow-up capture.
    prep(0, 320);
    out_rdy = 1'b0;
    start_capture(2'd0, 16'd320);
    for (int n = 0; n < 300 && word_cnt < 4'd3; n++) tick();
    check("abort_reached_3_words", 64'(word_cnt), 64'd3);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy",     {63'd0, busy},    64'd0);
    check("abort_out_val",  {63'd0, out_val}, 64'd0);
    check("abort_word_cnt", 64'(word_cnt),    64'd0);
    check("abort_sc_sen",   {63'd0, sc_sen},  64'd0);
    repeat (3) tick();
    check("abort_no_done", 64'(done_cnt), 64'd0);
    out_rdy = 1'b1;
    src_words[0] = 32'h0F0F1234;
    prep(0, 32);
    start_capture(2'd0, 16'd32);
    run_to_done("post_abort", 200);
    check("post_abort_nwords", 64'(got.size()), 64'd1);
    if (got.size() == 1) check("post_abort_word", 64'(got[0]), 64'h0F0F1234);

    // Start while busy is ignored: chain 1 and 64 bits stay latched.
    src_words[0] = 32'h5A5AC3C3; src_words[1] = 32'h00FF00FF;
    prep(1, 64);
    start_capture(2'd1, 16'd64);
    repeat (5) tick();
    start_capture(2'd0, 16'd0);
    run_to_done("ignore_start", 300);
    check("ignore_start_nwords", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("ignore_start_word0", 64'(got[0]), 64'h5A5AC3C3);
      check("ignore_start_word1", 64'(got[1]), 64'h00FF00FF);
    end
    check("ignore_start_sen_cycles", 64'(sen_cycles), 64'd64);

    // Reset in the middle of a capture with a word queued.
    prep(2, 64);
    out_rdy = 1'b0;
    start_capture(2'd2, 16'd64);
    repeat (40) tick();
    check("midrst_word_queued", 64'(word_cnt), 64'd1);
    reset = 1'b1;
    tick();
    check("midrst_sc_sen",   {63'd0, sc_sen},  64'd0);
    check("midrst_out_val",  {63'd0, out_val}, 64'd0);
    check("midrst_busy",     {63'd0, busy},    64'd0);
    check("midrst_done",     {63'd0, done},    64'd0);
    check("midrst_word_cnt", 64'(word_cnt),    64'd0);
    check("midrst_out_data", 64'(out_data),    64'd0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
